ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
- Shares one AHB-lite slave port (HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HBURST in; HREADYOUT/HRESP/HRDATA out) between NUM_REQ simple valid/ready requesters.
- Round-robin arbitration; issues single NONSEQ transfers.
- Pipelines the next address phase over the current data phase, honours wait states and the two-cycle ERROR response.
- Returns one response per transfer, tagged with the requester id.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width.
- TIMEOUT_CYCLES, 256, wait-state watchdog limit (used only with the optional feature).

Ports:
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  request accepted (address phase completed).
- req_addr  in  NUM_REQ*ADDR_W  flattened; slice i belongs to requester i.
- req_write  in  NUM_REQ  1 = write.
- req_size  in  NUM_REQ*3  HSIZE code.
- req_wdata  in  NUM_REQ*DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  owner of the response.
- rsp_rdata  out  DATA_W  HRDATA for reads, 0 for writes.
- rsp_err  out  1  HRESP[0] at completion.
- HSEL  out  1  slave select.
- HADDR  out  ADDR_W  address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ only.
- HSIZE  out  3  transfer size.
- HWRITE  out  1  write.
- HBURST  out  3  constant 000 (SINGLE).
- HWDATA  out  DATA_W  data-phase write data.
- HREADY  in  1  slave HREADYOUT.
- HRESP  in  2  bit0 = ERROR.
- HRDATA  in  DATA_W  read data.
- timeout_flag  out  1  sticky watchdog flag.

Behaviour:
- Reset: every register clears synchronously while HRESET = 1.
  - HSEL=0, HTRANS=00, HADDR/HSIZE/HWRITE/HWDATA=0, HBURST=000.
  - req_ready=0, rsp_valid=0, rsp_id/rsp_rdata/rsp_err=0, rr pointer=0, timeout_flag=0.
  - Reset mid-transfer discards in-flight work; no rsp_valid is produced for it.
- Address-phase register (AP): valid, id, addr, size, write, wdata. Drives HSEL=1 and HTRANS=10 when valid; otherwise HSEL=0 and HTRANS=00.
- Data-phase register (DP): valid, id, write, wdata. HWDATA = DP.wdata.
- Arbitration:
  - AP is loaded when it is empty or completing (AP.valid & HREADY).
  - Winner is the lowest index at or after rr pointer with req_valid=1.
  - The requester whose AP completes in this cycle is masked.
  - On load, rr pointer = winner+1 mod NUM_REQ.
  - Latency: req_valid at cycle t, with AP and DP idle, gives HTRANS=NONSEQ at t+1.
- Grant lock: AP holds stable while HREADY=0; there is no re-arbitration during wait states.
- req_ready[i] = AP.valid & AP.id==i & HREADY & ~cancel (combinational).
  - Requester holds all fields stable while valid & ~ready.
  - It may drop or change them the cycle after ready.
- Throughput:
  - Two or more active requesters: one transfer per cycle with zero-wait slaves.
  - A single requester gets one transfer per two cycles (mask bubble).
- Completion: AP.valid & HREADY moves AP into DP.
- Response:
  - DP.valid & HREADY produces rsp_valid=1 for exactly one cycle, rsp_id=DP.id, rsp_err=HRESP[0].
  - rsp_rdata = DP.write ? 0 : HRDATA.
  - DP clears unless a new AP moves in on the same edge.
- ERROR handling:
  - First error cycle: DP.valid, HRESP[0]=1, HREADY=0.
  - The pending AP is cancelled: AP.valid clears, so HTRANS=00 in the second error cycle, and req_ready is not given.
  - The cancelled requester re-arbitrates normally.
- Responses return in issue order; at most 2 transfers are in flight.

Optional Feature:
- Macro: AHB_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle with DP.valid & ~HREADY and resets on HREADY.
  - When it reaches TIMEOUT_CYCLES, timeout_flag sets and stays set until HRESET.
  - Bus behaviour is unchanged.
- Undefined: the counter is absent and timeout_flag is tied to 0.

Decomposition:
- Package ahb_arb_pkg holds:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP_OKAY / HRESP_ERROR constants.
  - HSIZE_BYTE/HALF/WORD codes.
  - HBURST_SINGLE.
- Sub-module ahb_rr_arbiter:
  - Inputs: req vector, mask vector, pointer.
  - Outputs: winner index and found.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset, then req0 write addr 0x100 data 0xDEADBEEF, zero-wait slave -> HTRANS=10, HADDR=0x100 at t+1; HWDATA=0xDEADBEEF at t+2; rsp_valid at t+2 with rsp_id=0, rsp_err=0.
- req0 and req1 both reading, held continuously -> grants alternate 0,1,0,1; one NONSEQ per cycle; rsp_id sequence matches.
- Slave inserts 3 wait states on a read of 0x200 while req1 is pending -> HADDR/HTRANS for req1 held 3 cycles; no req_ready during the waits; read returns HRDATA=0x12345678.
- ERROR two-cycle response on req0 with req1's address pending -> rsp_err=1 for req0; HTRANS=00 in the second error cycle; req1 re-issued afterwards and completes OK.
- HRESET asserted during a wait state -> next cycle all outputs at reset values; no rsp_valid for the aborted transfer.
- With AHB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: hold HREADY=0 for 8 cycles -> timeout_flag=1 and stays 1 until HRESET.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared AHB-lite encodings for the multi-requester master arbiter.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr.
module ahb_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               found
);

  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx] && !mask[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin sharing of one AHB-lite slave port among NUM_REQ requesters.
// Optional wait-state watchdog: define AHB_ARB_TIMEOUT_EN.
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*3-1:0]        req_size,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        HSEL,
  output logic [ADDR_W-1:0]           HADDR,
  output logic [1:0]                  HTRANS,
  output logic [2:0]                  HSIZE,
  output logic                        HWRITE,
  output logic [2:0]                  HBURST,
  output logic [DATA_W-1:0]           HWDATA,
  input  logic                        HREADY,
  input  logic [1:0]                  HRESP,
  input  logic [DATA_W-1:0]           HRDATA,
  output logic                        timeout_flag
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic              ap_valid;
  logic [IDW-1:0]    ap_id;
  logic [ADDR_W-1:0] ap_addr;
  logic [2:0]        ap_size;
  logic              ap_write;
  logic [DATA_W-1:0] ap_wdata;

  logic              dp_valid;
  logic [IDW-1:0]    dp_id;
  logic              dp_write;
  logic [DATA_W-1:0] dp_wdata;

  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] arb_mask;
  logic [IDW-1:0]     arb_winner;
  logic               arb_found;

  logic ap_done;
  logic err_first;
  logic ap_load;

  assign ap_done   = ap_valid & HREADY;
  assign err_first = dp_valid & HRESP[0] & ~HREADY;
  // No new address phase may appear during the first ERROR cycle, so the
  // bus shows IDLE in the second one.
  assign ap_load   = ~err_first & (~ap_valid | HREADY);

  always_comb begin
    arb_mask = '0;
    if (ap_done) arb_mask[ap_id] = 1'b1;
  end

  ahb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req    (req_valid),
    .mask   (arb_mask),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .found  (arb_found)
  );

  always_comb begin
    req_ready = '0;
    if (ap_valid && HREADY && !err_first) req_ready[ap_id] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_valid <= 1'b0;
      ap_id    <= '0;
      ap_addr  <= '0;
      ap_size  <= '0;
      ap_write <= 1'b0;
      ap_wdata <= '0;
      rr_ptr   <= '0;
    end else if (ap_load) begin
      ap_valid <= arb_found;
      if (arb_found) begin
        ap_id    <= arb_winner;
        ap_addr  <= req_addr[32'(arb_winner)*ADDR_W +: ADDR_W];
        ap_size  <= req_size[32'(arb_winner)*3 +: 3];
        ap_write <= req_write[arb_winner];
        ap_wdata <= req_wdata[32'(arb_winner)*DATA_W +: DATA_W];
        rr_ptr   <= (arb_winner == IDW'(NUM_REQ-1)) ? '0 : arb_winner + IDW'(1);
      end
    end else if (err_first) begin
      ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_id    <= '0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (HREADY) begin
      dp_valid <= ap_valid;
      if (ap_valid) begin
        dp_id    <= ap_id;
        dp_write <= ap_write;
        dp_wdata <= ap_wdata;
      end
    end
  end

  assign HSEL   = ap_valid;
  assign HTRANS = ap_valid ? NONSEQ : IDLE;
  assign HADDR  = ap_addr;
  assign HSIZE  = ap_size;
  assign HWRITE = ap_write;
  assign HBURST = HBURST_SINGLE;
  assign HWDATA = dp_wdata;

  assign rsp_valid = dp_valid & HREADY;
  assign rsp_id    = dp_id;
  assign rsp_err   = rsp_valid & HRESP[0];
  assign rsp_rdata = (rsp_valid && !dp_write) ? HRDATA : '0;

  logic unused_inputs;
  assign unused_inputs = HRESP[1];

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          tmo_flag;

  // Counter saturates at the limit; the flag is sticky until reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
    end else if (HREADY) begin
      wait_cnt <= '0;
    end else if (dp_valid) begin
      if (wait_cnt != TW'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + TW'(1);
      if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) tmo_flag <= 1'b1;
    end
  end

  assign timeout_flag = tmo_flag;
`else
  logic unused_tmo;
  assign unused_tmo   = (TIMEOUT_CYCLES == 0);
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Randomized bench for ahb_master_arbiter with a transaction-level reference.
module tb_ahb_master_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int NCYC = 3000;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [N-1:0]    req_valid, req_ready, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*3-1:0]  req_size;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_err;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            HSEL, HWRITE, HREADY;
  logic [AW-1:0]   HADDR;
  logic [1:0]      HTRANS, HRESP;
  logic [2:0]      HSIZE, HBURST;
  logic [DW-1:0]   HWDATA, HRDATA;
  logic            timeout_flag;

  ahb_master_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HSIZE        (HSIZE),
    .HWRITE       (HWRITE),
    .HBURST       (HBURST),
    .HWDATA       (HWDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .HRDATA       (HRDATA),
    .timeout_flag (timeout_flag)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    int          ws;
    bit          err;
    bit          estage;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t new_txn(input int i);
    txn_t t;
    logic [31:0] r;
    r       = $urandom();
    t.id    = i;
    t.addr  = {r[31:16], 4'(i), r[11:2], 2'b00};
    t.size  = 3'($urandom_range(0, 2));
    t.wr    = 1'($urandom % 2);
    t.wdata = $urandom();
    t.ws    = 0;
    t.err   = 1'b0;
    t.estage = 1'b0;
    return t;
  endfunction

  function automatic txn_t slave_plan(input txn_t tin);
    txn_t t;
    int   r;
    t = tin;
    r = int'($urandom % 16);
    if (r < 10)       t.ws = 0;
    else if (r < 14)  t.ws = r - 10;
    else              t.ws = 9;
    t.err    = ($urandom % 7) == 0;
    t.estage = 1'b0;
    return t;
  endfunction

  // Reference state: requester heads, pending address phase, accepted transfers
  txn_t cur[N];
  bit   cur_v[N];
  bit   m_ap_v;
  txn_t m_ap;
  txn_t flight[$];
  int   ptr;
  int   run;
  bit   m_flag;
  bit   just_reset;

  initial begin
    txn_t t;
    bit   rst_now, hr, er, err1, ap_done, exp_rsp;
    int   done_id, w, idx, phase, prob;
    logic [N-1:0] exp_rdy;

    HRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_size = '0;
    req_wdata = '0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
    m_ap_v = 1'b0; ptr = 0; run = 0; m_flag = 1'b0; just_reset = 1'b1;
    repeat (2) @(posedge HCLK);

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge HCLK);
      #1;
      rst_now = (cyc < 2) ||
                (cyc > 50 && flight.size() > 0 && flight[0].ws > 0 && ($urandom % 25) == 0);
      HRESET = rst_now;

      phase = (cyc / 400) % 3;
      for (int i = 0; i < N; i++) begin
        prob = (phase == 0) ? 8 : (phase == 1) ? 3 : ((i == 0) ? 9 : 0);
        if (!cur_v[i] && int'($urandom % 10) < prob) begin
          cur[i]  = new_txn(i);
          cur_v[i] = 1'b1;
        end
        req_valid[i]            = cur_v[i] && !rst_now;
        req_addr[i*AW +: AW]    = cur[i].addr;
        req_size[i*3 +: 3]      = cur[i].size;
        req_write[i]            = cur[i].wr;
        req_wdata[i*DW +: DW]   = cur[i].wdata;
      end

      HRDATA = $urandom();
      if (rst_now) begin
        HREADY = 1'b0; HRESP = 2'b00;
      end else if (flight.size() == 0) begin
        HREADY = 1'b1; HRESP = 2'b00;
      end else if (flight[0].ws > 0) begin
        HREADY = 1'b0; HRESP = 2'b00;
      end else if (flight[0].err) begin
        HREADY = flight[0].estage; HRESP = 2'b01;
      end else begin
        HREADY = 1'b1; HRESP = 2'b00;
      end

      @(negedge HCLK);
      hr   = HREADY;
      er   = HRESP[0];
      err1 = flight.size() > 0 && er && !hr;
      ap_done = m_ap_v && hr;

      exp_rdy = '0;
      if (m_ap_v && hr && !err1) exp_rdy[m_ap.id] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("hsel", 64'(HSEL), 64'(m_ap_v));
      chk("htrans", 64'(HTRANS), 64'(m_ap_v ? 2'b10 : 2'b00));
      chk("hburst", 64'(HBURST), 64'(0));
      if (m_ap_v) begin
        chk("haddr", 64'(HADDR), 64'(m_ap.addr));
        chk("hsize", 64'(HSIZE), 64'(m_ap.size));
        chk("hwrite", 64'(HWRITE), 64'(m_ap.wr));
      end
      if (flight.size() > 0) chk("hwdata", 64'(HWDATA), 64'(flight[0].wdata));
      exp_rsp = flight.size() > 0 && hr;
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      if (exp_rsp) begin
        chk("rsp_id", 64'(rsp_id), 64'(flight[0].id));
        chk("rsp_err", 64'(rsp_err), 64'(er));
        chk("rsp_rdata", 64'(rsp_rdata), flight[0].wr ? 64'(0) : 64'(HRDATA));
      end
      chk("timeout_flag", 64'(timeout_flag), 64'(m_flag));
      if (just_reset) begin
        chk("rst_haddr", 64'(HADDR), 64'(0));
        chk("rst_hsize", 64'(HSIZE), 64'(0));
        chk("rst_hwrite", 64'(HWRITE), 64'(0));
        chk("rst_hwdata", 64'(HWDATA), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      end

      if (rst_now) begin
        m_ap_v = 1'b0; flight.delete(); ptr = 0; run = 0; m_flag = 1'b0;
        just_reset = 1'b1;
      end else begin
        just_reset = 1'b0;
        if (hr) run = 0;
        else if (flight.size() > 0) begin
          run++;
`ifdef AHB_ARB_TIMEOUT_EN
          if (run >= TMO) m_flag = 1'b1;
`endif
        end

        if (flight.size() > 0) begin
          if (hr) void'(flight.pop_front());
          else begin
            t = flight[0];
            if (t.ws > 0) t.ws--;
            else t.estage = 1'b1;
            flight[0] = t;
          end
        end

        done_id = ap_done ? m_ap.id : -1;
        if (ap_done) begin
          flight.push_back(slave_plan(m_ap));
          cur_v[done_id] = 1'b0;
        end

        if (err1) m_ap_v = 1'b0;
        else if (!m_ap_v || ap_done) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (w < 0 && req_valid[idx] && idx != done_id) w = idx;
          end
          if (w >= 0) begin
            m_ap = cur[w]; m_ap_v = 1'b1; ptr = (w + 1) % N;
          end else begin
            m_ap_v = 1'b0;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
